seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's multiplexed 7-segment scan driver.
- Samples the scanned `seg_data`/`seg_cs` bus, debounces each digit slot and decodes the segment pattern back to a 4-bit hex value plus decimal point.
- Exposes the four reconstructed digits, with error and frame status, for loopback self-test and bench checking of display drivers.

Parameters:
- STABLE_CYCLES, 4, consecutive identical registered samples required to commit a digit (>=2).
- TIMEOUT_CYCLES, 4000, cycles without any commit before `stall_o` asserts.

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_data_i  in  8  segment bus; [6:0] = segments g..a, [7] = dp, active-high
- seg_cs_i  in  4  digit select, one-hot active-high; bit n selects digit n
- digits_o  out  16  decoded digits; [4n+3:4n] = digit n
- dp_o  out  4  decimal point of digit n
- err_o  out  4  digit n last committed an undecodable pattern
- frame_o  out  1  one-cycle pulse when all four digits have been committed since the last pulse
- cs_err_o  out  1  one-cycle pulse when a new multi-hot `seg_cs_i` value is sampled
- stall_o  out  1  no commit for TIMEOUT_CYCLES cycles

Behaviour:
- **Reset:** asynchronous and active-low; all outputs, registers, counters and the commit bitmap go to 0; FSM to WAIT.
- **Input stage:** one register stage; `s_q = {seg_cs_i, seg_data_i}`, with `s_prev` holding the previous `s_q`. `s_q` is compared against `s_prev` every cycle ("changed").
- **FSM states:** WAIT, COUNT, HELD. Transitions:
  - Any state, changed and `seg_cs` one-hot -> COUNT, `cnt = 1`.
  - Any state, changed and `seg_cs` all-zero (blanking) -> WAIT, silent.
  - Any state, changed and `seg_cs` multi-hot -> WAIT, `cs_err_o` pulses 1 cycle.
  - COUNT, unchanged -> `cnt++`; when `cnt` reaches STABLE_CYCLES, commit and go to HELD.
  - HELD, unchanged -> stay; no re-commit.
  - WAIT, unchanged -> stay.
- **Commit to digit n** (n = index of the one-hot bit):
  - `dp_o[n]` is always set to `data[7]`.
  - If `data[6:0]` matches the pattern table: `digits_o[n]` is set to the decoded value and `err_o[n]` is cleared.
  - Otherwise: `digits_o[n]` is unchanged and `err_o[n]` is set.
  - In both cases bitmap bit n is set.
- **Latency:** an input applied before edge k and held constant through edge k+S (S = STABLE_CYCLES) is visible on the outputs after edge k+S+1.
- **Frame:** when a commit makes the bitmap 4'b1111, `frame_o` pulses in the same cycle the outputs update and the bitmap clears to 0. Re-committing a digit already in the bitmap updates its value but does not change the bitmap.
- **Stall:** a cycle counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - `stall_o = (counter == TIMEOUT_CYCLES)`.
  - A commit clears the counter to 0 and drops `stall_o` on the same edge.
- **Counter widths:** `$clog2(param+1)`; no wrap-around is permitted.
- **Pattern table** (hex 0..F on [6:0]): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 58 5E 79 71. This is bit-exact with the team's scan driver after masking [7].
- **Reset mid-operation:** a pending count is discarded and no commit occurs.

Decomposition:
- **Package `seg7_pkg`:**
  - `NUM_DIGITS = 4`
  - 16-entry 7-bit segment pattern table, shared with the driver
  - FSM state typedef `{WAIT, COUNT, HELD}`
- **Sub-module `seg7_pattern_decode`:** combinational. Takes `[6:0]` and returns `{valid, value[3:0]}`. It is reused by the driver testbench.

Test Plan:
1. **Reset:** hold `rst_n` = 0 with active inputs -> `digits_o` = 0, `dp_o` = 0, `err_o` = 0, `frame_o` = 0, `stall_o` = 0. Release -> all remain 0 until a commit.
2. **Single commit and latency:** `seg_cs_i` = 0001, `seg_data_i` = 0x06 held 4 cycles -> `digits_o[3:0]` = 1 exactly S+1 edges after first presentation. Then `seg_cs_i` = 0010, `seg_data_i` = 0xBF -> `digits_o[7:4]` = 0, `dp_o[1]` = 1.
3. **Full scan:** 0x3F/0001, 0x66/0010, 0x06/0100, 0x6F/1000, each for 10 cycles -> `digits_o` = 16'h9140. `frame_o` is exactly one pulse, coincident with the digit-3 update, and none during a repeat scan until all four digits recommit.
4. **Glitch rejection:** 0x5B on 0100 for 3 cycles, then 0x4F -> no commit on the 0x5B. 0x4F held 4 cycles -> `digits_o[11:8]` = 3.
5. **Undecodable pattern:** 0x00 on 0100 -> `err_o[2]` = 1 and `digits_o[11:8]` unchanged. Then 0x5B -> digit 2 = 2 and `err_o[2]` = 0. Also: 0x7C on 1000 decodes to B.
6. **Chip-select errors, stall, reset mid-count:**
   - `seg_cs_i` = 0011 -> one `cs_err_o` pulse and no commit.
   - With TIMEOUT_CYCLES = 20 and static inputs -> `stall_o` rises 20 cycles after the last commit and clears on the next commit.
   - `rst_n` pulse at cnt = 2 -> no commit after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment pattern table and scan-FSM state type
// for the 7-segment scan driver and its receive-side decoder.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment patterns for hex 0..F on [6:0] (g..a, active-high); entry i encodes value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {WAIT, COUNT, HELD} scan_state_t;

    // Bit position of a one-hot digit select; only meaningful when exactly one bit is set.
    function automatic logic [1:0] onehot_index(input logic [NUM_DIGITS-1:0] cs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (cs[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment-pattern to hex decoder.
//   seg   in  7  segment pattern, [6:0] = g..a
//   valid out 1  pattern found in the table
//   value out 4  decoded hex value (0 when not valid)
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b0;
        value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_TABLE[i] == seg) begin
                valid = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment scan bus, debounces each
// digit slot and reconstructs the four displayed hex digits and decimal points.
//   clk_i       in  1   system clock
//   rst_n       in  1   asynchronous active-low reset
//   seg_data_i  in  8   [6:0] segments g..a, [7] dp, active-high
//   seg_cs_i    in  4   one-hot digit select
//   digits_o    out 16  digit n on [4n+3:4n]
//   dp_o        out 4   decimal point per digit
//   err_o       out 4   digit last committed an undecodable pattern
//   frame_o     out 1   pulse when all four digits committed since last pulse
//   cs_err_o    out 1   pulse on a newly sampled multi-hot select
//   stall_o     out 1   no commit for TIMEOUT_CYCLES cycles
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [7:0]  seg_data_i,
    input  logic [3:0]  seg_cs_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_o,
    output logic [3:0]  err_o,
    output logic        frame_o,
    output logic        cs_err_o,
    output logic        stall_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] STALL_MAX = TW'(TIMEOUT_CYCLES);

    logic [11:0]           s_q, s_prev;
    logic [NUM_DIGITS-1:0] cs;
    logic [7:0]            data;
    logic                  changed, cs_zero, cs_onehot;
    scan_state_t           state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  commit, cs_err_nx;
    logic [1:0]            idx;
    logic                  dec_valid;
    logic [3:0]            dec_value;
    logic [3:0]            bitmap, bitmap_set;
    logic [TW-1:0]         stall_cnt;

    assign cs         = s_q[11:8];
    assign data       = s_q[7:0];
    assign changed    = s_q != s_prev;
    assign cs_zero    = cs == '0;
    assign cs_onehot  = !cs_zero && ((cs & (cs - 4'd1)) == 4'd0);
    assign idx        = onehot_index(cs);
    assign bitmap_set = bitmap | (4'd1 << idx);
    assign stall_o    = stall_cnt == STALL_MAX;

    seg7_pattern_decode u_decode (
        .seg   (data[6:0]),
        .valid (dec_valid),
        .value (dec_value)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            s_prev <= '0;
            state  <= WAIT;
            cnt    <= '0;
        end else begin
            s_q    <= {seg_cs_i, seg_data_i};
            s_prev <= s_q;
            state  <= state_nx;
            cnt    <= cnt_nx;
        end
    end

    // Any change restarts debouncing; the commit fires on the first unchanged
    // cycle after the count has reached STABLE_CYCLES, then HELD blocks repeats.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        commit    = 1'b0;
        cs_err_nx = 1'b0;
        if (changed) begin
            state_nx  = cs_onehot ? COUNT : WAIT;
            cnt_nx    = cs_onehot ? CW'(1) : '0;
            cs_err_nx = !cs_onehot && !cs_zero;
        end else if (state == COUNT) begin
            if (cnt == CNT_DONE) begin
                commit   = 1'b1;
                state_nx = HELD;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            digits_o <= '0;
            dp_o     <= '0;
            err_o    <= '0;
            frame_o  <= 1'b0;
            cs_err_o <= 1'b0;
            bitmap   <= '0;
        end else begin
            frame_o  <= 1'b0;
            cs_err_o <= cs_err_nx;
            if (commit) begin
                dp_o[idx]  <= data[7];
                err_o[idx] <= !dec_valid;
                if (dec_valid) digits_o[{idx, 2'b00} +: 4] <= dec_value;
                // Completing the set emits the frame pulse and starts a fresh set.
                bitmap  <= (bitmap_set == 4'hF) ? 4'h0 : bitmap_set;
                frame_o <= bitmap_set == 4'hF;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (commit) stall_cnt <= '0;
        else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + TW'(1);
    end

endmodule
